vec_apply_capture: RTL and testbench

VEC_APPLY_CAPTURE -- requirements
Module: vec_apply_capture

---
 rtl/vec_apply_capture.sv | 183 ++++++++++++++++++
 tb/tb_vec_apply_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_apply_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vec_apply_capture
//  Brief    : Applies stored stimulus vectors to a circuit under test, samples
//             its response CAP_DLY cycles later, compacts responses into a
//             MISR signature and compares them against expected values.
//  Revision : 1.0  initial release
// ============================================================================
module vec_apply_capture #(
  parameter int                 IN_W    = 5,
  parameter int                 OUT_W   = 2,
  parameter int                 DEPTH   = 32,
  parameter int                 CAP_DLY = 1,
  parameter int                 SIG_W   = 16,
  parameter logic [SIG_W-1:0]   POLY    = 16'h1021,
  localparam int                AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_en_i,
  input  logic                  ld_sel_i,
  input  logic [AW-1:0]         ld_addr_i,
  input  logic [IN_W-1:0]       ld_data_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  loop_mode_i,
  input  logic [AW:0]           num_vec_i,
  output logic [IN_W-1:0]       dut_in_o,
  input  logic [OUT_W-1:0]      dut_out_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [SIG_W-1:0]      sig_o,
  output logic [15:0]           err_cnt_o,
  output logic [AW-1:0]         first_err_o,
  output logic                  err_seen_o,
  output logic [15:0]           pass_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0]  C_CAP_DLY = 4'(CAP_DLY);
  localparam logic [AW:0] C_DEPTH   = (AW+1)'(DEPTH);

  // Pattern memories (not reset so patterns survive a reset)
  logic [IN_W-1:0]  stim_mem_q [DEPTH];
  logic [OUT_W-1:0] exp_mem_q  [DEPTH];

  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic [AW:0]      nvec_q;
  logic             loop_q;
  logic [3:0]       wait_q;
  logic [IN_W-1:0]  dut_in_q;
  logic             done_q;
  logic [SIG_W-1:0] sig_q;
  logic [15:0]      err_cnt_q;
  logic [AW-1:0]    first_err_q;
  logic             err_seen_q;
  logic [15:0]      pass_cnt_q;

  // Capture-edge next values
  logic             cap_edge;
  logic             last_vec;
  logic             mismatch;
  logic             start_ok;
  logic [AW-1:0]    idx_d;
  logic [SIG_W-1:0] sig_d;
  logic [15:0]      err_cnt_d;
  logic [AW-1:0]    first_err_d;
  logic             err_seen_d;
  logic [15:0]      pass_cnt_d;

  // Next-state values for the capture edge: MISR step, compare, counters
  always_comb begin
    cap_edge    = (wait_q == 4'd1);
    last_vec    = ({1'b0, idx_q} == (nvec_q - 1'b1));
    mismatch    = (dut_out_i != exp_mem_q[idx_q]);
    start_ok    = (num_vec_i != '0) && (num_vec_i <= C_DEPTH);
    idx_d       = last_vec ? '0 : idx_q + 1'b1;
    sig_d       = {sig_q[SIG_W-2:0], 1'b0}
                ^ (sig_q[SIG_W-1] ? POLY : '0)
                ^ SIG_W'(dut_out_i);
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_seen_d  = err_seen_q;
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (!err_seen_q) begin
        first_err_d = idx_q;
        err_seen_d  = 1'b1;
      end
    end
    pass_cnt_d  = last_vec ? pass_cnt_q + 16'd1 : pass_cnt_q;
  end

  // Memory load port, active only while idle
  always_ff @(posedge clk) begin
    if (ld_en_i && (state_q == IDLE)) begin
      if (ld_sel_i) begin
        exp_mem_q[ld_addr_i] <= ld_data_i[OUT_W-1:0];
      end else begin
        stim_mem_q[ld_addr_i] <= ld_data_i;
      end
    end
  end

  // Run controller: start/abort, vector application and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      nvec_q      <= '0;
      loop_q      <= 1'b0;
      wait_q      <= '0;
      dut_in_q    <= '0;
      done_q      <= 1'b0;
      sig_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '1;
      err_seen_q  <= 1'b0;
      pass_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort takes priority over a simultaneous start
          if (start_i && !abort_i && start_ok) begin
            state_q     <= RUN;
            idx_q       <= '0;
            dut_in_q    <= stim_mem_q[0];
            sig_q       <= '0;
            err_cnt_q   <= '0;
            err_seen_q  <= 1'b0;
            pass_cnt_q  <= '0;
            first_err_q <= '1;
            nvec_q      <= num_vec_i;
            loop_q      <= loop_mode_i;
            wait_q      <= C_CAP_DLY;
          end
        end
        RUN: begin
          if (abort_i) begin
            // stop without capturing; results are left visible
            state_q <= IDLE;
          end else if (cap_edge) begin
            sig_q       <= sig_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            pass_cnt_q  <= pass_cnt_d;
            wait_q      <= C_CAP_DLY;
            if (last_vec && !loop_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q    <= idx_d;
              dut_in_q <= stim_mem_q[idx_d];
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in_o    = dut_in_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign sig_o       = sig_q;
  assign err_cnt_o   = err_cnt_q;
  assign first_err_o = first_err_q;
  assign err_seen_o  = err_seen_q;
  assign pass_cnt_o  = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_apply_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vec_apply_capture
//  Brief    : Self-checking bench for vec_apply_capture. A small combinational
//             "circuit under test" turns dut_in into dut_out; expected results
//             are derived from the pattern arrays held in the bench.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_apply_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0, ld_en2 = 1'b0, ld_sel = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [4:0]  ld_data = '0;
  logic        start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic        loop_mode = 1'b0;
  logic [5:0]  num_vec = '0;
  logic        ovr_en = 1'b0;
  logic [1:0]  ovr_val = '0;

  logic [4:0]  dut_in1, dut_in2;
  logic [1:0]  dut_out1, dut_out2;
  logic        busy1, done1, seen1, busy2, done2, seen2;
  logic [15:0] sig1, err1, pass1, sig2, err2, pass2;
  logic [4:0]  ferr1, ferr2;

  int checks = 0;
  int errors = 0;

  // Reference pattern memories and expected result state
  logic [4:0]  m_stim [32];
  logic [1:0]  m_exp  [32];
  logic [15:0] e_sig;
  int          e_err;
  logic [4:0]  e_first;
  logic        e_seen;
  int          e_pass;

  always #5 clk = ~clk;

  function automatic logic [1:0] cut_f(input logic [4:0] v);
    return {v[4] ^ v[1] ^ v[0], v[3] ^ v[2]};
  endfunction

  assign dut_out1 = ovr_en ? ovr_val : cut_f(dut_in1);
  assign dut_out2 = cut_f(dut_in2);

  vec_apply_capture u_dut (
    .clk(clk), .rst_n(rst_n), .ld_en_i(ld_en), .ld_sel_i(ld_sel),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .start_i(start),
    .abort_i(abort), .loop_mode_i(loop_mode), .num_vec_i(num_vec),
    .dut_in_o(dut_in1), .dut_out_i(dut_out1), .busy_o(busy1),
    .done_o(done1), .sig_o(sig1), .err_cnt_o(err1), .first_err_o(ferr1),
    .err_seen_o(seen1), .pass_cnt_o(pass1)
  );

  vec_apply_capture #(.CAP_DLY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ld_en_i(ld_en2), .ld_sel_i(ld_sel),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .start_i(start2),
    .abort_i(abort2), .loop_mode_i(loop_mode), .num_vec_i(num_vec),
    .dut_in_o(dut_in2), .dut_out_i(dut_out2), .busy_o(busy2),
    .done_o(done2), .sig_o(sig2), .err_cnt_o(err2), .first_err_o(ferr2),
    .err_seen_o(seen2), .pass_cnt_o(pass2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    e_sig = '0; e_err = 0; e_first = 5'h1F; e_seen = 1'b0; e_pass = 0;
  endfunction

  // One capture of response resp for vector k, straight from the rules
  function automatic void model_capture(input logic [1:0] resp, input int k);
    e_sig = {e_sig[14:0], 1'b0} ^ (e_sig[15] ? 16'h1021 : 16'h0000) ^ {14'b0, resp};
    if (resp != m_exp[k]) begin
      if (e_err < 65535) e_err++;
      if (!e_seen) begin
        e_seen  = 1'b1;
        e_first = 5'(k);
      end
    end
  endfunction

  task automatic chk_res1(input string tag);
    chk({tag, "_sig"},   sig1,  e_sig);
    chk({tag, "_err"},   err1,  e_err);
    chk({tag, "_first"}, ferr1, e_first);
    chk({tag, "_seen"},  seen1, e_seen);
    chk({tag, "_pass"},  pass1, e_pass);
  endtask

  task automatic load(input logic sel, input int addr, input logic [4:0] data);
    ld_en = 1'b1; ld_en2 = 1'b1; ld_sel = sel; ld_addr = 5'(addr); ld_data = data;
    step();
    ld_en = 1'b0; ld_en2 = 1'b0;
    if (sel) m_exp[addr] = data[1:0];
    else     m_stim[addr] = data;
  endtask

  task automatic start1(input int nv, input logic lp);
    num_vec = 6'(nv); loop_mode = lp; start = 1'b1;
    step();
    start = 1'b0; loop_mode = 1'b0;
    model_reset();
  endtask

  // Complete non-looping run on the CAP_DLY=1 instance; poke=1 also tries
  // a restart and a memory write in the middle of the run
  task automatic run1(input int nv, input bit poke);
    logic [1:0] resp;
    start1(nv, 1'b0);
    chk("start_busy", busy1, 1);
    chk("start_din", dut_in1, m_stim[0]);
    for (int k = 0; k < nv; k++) begin
      if (poke && k == 1) begin
        start = 1'b1; num_vec = 6'd1;
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 5'd0; ld_data = ~m_stim[0];
      end
      resp = ovr_en ? ovr_val : cut_f(m_stim[k]);
      model_capture(resp, k);
      step();
      start = 1'b0; ld_en = 1'b0;
      if (k < nv - 1) begin
        chk("run_din", dut_in1, m_stim[k+1]);
        chk("run_busy", busy1, 1);
        chk("run_done", done1, 0);
      end else begin
        chk("end_done", done1, 1);
        chk("end_busy", busy1, 0);
        chk("end_din_hold", dut_in1, m_stim[nv-1]);
      end
    end
    e_pass = 1;
    chk_res1("end");
    step();
    chk("done_pulse_len", done1, 0);
  endtask

  // Run nv vectors, abort after j captures (abort edge is a capture edge)
  task automatic abort1(input int nv, input int j);
    start1(nv, 1'b0);
    for (int k = 0; k < j; k++) begin
      model_capture(cut_f(m_stim[k]), k);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_din_hold", dut_in1, m_stim[j]);
    chk_res1("abort");
    step();
    chk("abort_no_done", done1, 0);
  endtask

  // Looping run on the CAP_DLY=3 instance for T cycles, then abort
  task automatic loop3(input int nv, input int T);
    int m;
    num_vec = 6'(nv); loop_mode = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0; loop_mode = 1'b0;
    model_reset();
    chk("loop_start_din", dut_in2, m_stim[0]);
    chk("loop_start_busy", busy2, 1);
    for (int t = 1; t <= T; t++) begin
      step();
      if (t % 3 == 0) begin
        m = (t / 3 - 1) % nv;
        model_capture(cut_f(m_stim[m]), m);
        if (m == nv - 1) e_pass++;
      end
      chk("loop_din", dut_in2, m_stim[(t / 3) % nv]);
      chk("loop_done", done2, 0);
    end
    abort2 = 1'b1;
    step();
    abort2 = 1'b0;
    chk("loop_abort_busy", busy2, 0);
    chk("loop_abort_done", done2, 0);
    chk("loop_sig", sig2, e_sig);
    chk("loop_err", err2, e_err);
    chk("loop_first", ferr2, e_first);
    chk("loop_seen", seen2, e_seen);
    chk("loop_pass", pass2, e_pass);
    chk("loop_din_hold", dut_in2, m_stim[(T / 3) % nv]);
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    step(); step();
    chk("rst_din", dut_in1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_sig", sig1, 0);
    chk("rst_err", err1, 0);
    chk("rst_first", ferr1, 5'h1F);
    chk("rst_seen", seen1, 0);
    chk("rst_pass", pass1, 0);
    rst_n = 1'b1;
    step();

    // Directed example: three vectors, constant matching response
    load(1'b0, 0, 5'b00001); load(1'b0, 1, 5'b00010); load(1'b0, 2, 5'b00011);
    for (int i = 0; i < 3; i++) load(1'b1, i, 5'b00001);
    ovr_en = 1'b1; ovr_val = 2'b01;
    run1(3, 1'b0);
    chk("dir_sig", sig1, 16'h0007);
    chk("dir_err", err1, 0);
    load(1'b1, 1, 5'b00010);
    run1(3, 1'b0);
    chk("dir_err1", err1, 1);
    chk("dir_first1", ferr1, 1);
    chk("dir_sig1", sig1, 16'h0007);
    ovr_en = 1'b0;

    // Random patterns
    for (int i = 0; i < 32; i++) begin
      load(1'b0, i, 5'($urandom));
      load(1'b1, i, 5'($urandom));
    end
    run1(32, 1'b0);
    run1(1, 1'b0);
    run1(int'($urandom_range(3, 31)), 1'b1);
    run1(int'($urandom_range(2, 31)), 1'b0);
    abort1(10, 4);
    abort1(5, 0);

    // Illegal starts
    num_vec = 6'd0; start = 1'b1; step(); start = 1'b0;
    chk("nv0_busy", busy1, 0);
    num_vec = 6'd33; start = 1'b1; step(); start = 1'b0;
    chk("nv33_busy", busy1, 0);
    num_vec = 6'd5; start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy1, 0);

    // Reset mid-run, then rerun from preserved memories
    start1(8, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_din", dut_in1, 0);
    chk("mrst_busy", busy1, 0);
    chk("mrst_done", done1, 0);
    chk("mrst_sig", sig1, 0);
    chk("mrst_err", err1, 0);
    chk("mrst_first", ferr1, 5'h1F);
    chk("mrst_seen", seen1, 0);
    chk("mrst_pass", pass1, 0);
    step();
    chk("mrst_nodone", done1, 0);
    run1(8, 1'b0);

    // Looping with a 3-cycle period; abort lands on a would-be capture edge
    loop3(2, 14);
    loop3(int'($urandom_range(3, 7)), 38);

    // MISR feedback: walk a single 1 up to the MSB, then capture zero
    ovr_en = 1'b1; ovr_val = 2'b01;
    start1(32, 1'b0);
    step();
    ovr_val = 2'b00;
    repeat (15) step();
    chk("seed_sig", sig1, 16'h8000);
    step();
    chk("poly_sig", sig1, 16'h1021);
    abort = 1'b1; step(); abort = 1'b0;

    // Saturation: every capture mismatches
    for (int i = 0; i < 32; i++) load(1'b1, i, 5'b00000);
    ovr_val = 2'b11;
    start1(32, 1'b1);
    repeat (20000) step();
    chk("sat_err_mid", err1, 20000);
    repeat (45540) step();
    chk("sat_err", err1, 16'hFFFF);
    chk("sat_first", ferr1, 0);
    chk("sat_seen", seen1, 1);
    chk("sat_pass", pass1, 65540 / 32);
    abort = 1'b1; step(); abort = 1'b0;
    chk("sat_abort_busy", busy1, 0);
    ovr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
